// File: rtl/adc_packer_defs.sv
// Shared definitions for the ADC sample packer: FSM encodings, word geometry
// and a saturating counter helper.
package adc_packer_defs;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TICK = 2'd1,
    ST_SEND      = 2'd2
  } state_e;

  localparam int CH_PER_WORD = 4;
  localparam int WORD_W      = 64;

  // Dropped-tick counter sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/adc_tick_gen.sv
// Sample-rate divider: counts 0..DECIM-1 while enabled and flags the last count.
module adc_tick_gen #(
  parameter int DECIM = 40
) (
  input  logic data_clk,
  input  logic user_rstn,
  input  logic ena,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(DECIM - 1);

  logic [15:0] cnt_q, cnt_d;

  // Next count: wrap at LAST, parked at zero while disabled
  always_comb begin
    cnt_d = 16'd0;
    if (ena) begin
      if (cnt_q == LAST) begin
        cnt_d = 16'd0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end else begin
      cnt_d = 16'd0;
    end
  end

  // Counter register
  always_ff @(posedge data_clk or negedge user_rstn) begin
    if (!user_rstn) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = ena && (cnt_q == LAST);

endmodule

// File: rtl/adc_sample_packer.sv
// Snapshots all ADC channels once per tick and streams them as 64-bit AXIS words.
// Optional test pattern source enabled by macro ADC_PACKER_TEST_PATTERN_EN.
module adc_sample_packer
  import adc_packer_defs::*;
#(
  parameter int DECIM      = 40,
  parameter int SAMPLE_W   = 16,
  parameter int NUM_GROUPS = 16
) (
  input  logic                                data_clk,
  input  logic                                user_rstn,
  input  logic                                dma_ena,
  input  logic [NUM_GROUPS*4*SAMPLE_W-1:0]    adc_data,
  input  logic                                test_mode,
  output logic                                new_sample,
  output logic [63:0]                         m_axis_tdata,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic                                m_axis_tlast,
  output logic                                overrun,
  output logic [15:0]                         overrun_cnt
);

  localparam int GRP_W  = CH_PER_WORD * SAMPLE_W;
  localparam int DATA_W = NUM_GROUPS * GRP_W;
  localparam int GW     = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [GW-1:0] G_LAST = GW'(NUM_GROUPS - 1);

  logic [1:0]        rst_sync_q, rst_sync_d;
  logic              rst_n_s;
  logic              tick_s;
  state_e            state_q, state_d;
  logic [GW-1:0]     g_q, g_d, g_nxt_s;
  logic [DATA_W-1:0] snap_q, snap_d;
  logic [DATA_W-1:0] cap_data_s;
  logic [WORD_W-1:0] tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic              overrun_q, overrun_d;
  logic [15:0]       overrun_cnt_q, overrun_cnt_d;
  logic              dma_ena_q, dma_ena_d;
  logic              rise_s, hs_s, capture_s, drop_s;

  // Reset asserts asynchronously but releases on a clock edge
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Reset synchroniser register
  always_ff @(posedge data_clk or negedge user_rstn) begin
    if (!user_rstn) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_n_s = rst_sync_q[1];

  adc_tick_gen #(.DECIM(DECIM)) u_tick (
    .data_clk  (data_clk),
    .user_rstn (rst_n_s),
    .ena       (dma_ena),
    .tick      (tick_s)
  );

`ifdef ADC_PACKER_TEST_PATTERN_EN
  logic [SAMPLE_W-7:0] sample_idx_q, sample_idx_d;
  logic [DATA_W-1:0]   pattern_s;

  for (genvar c = 0; c < NUM_GROUPS * CH_PER_WORD; c++) begin : g_pat
    assign pattern_s[c*SAMPLE_W +: SAMPLE_W] = {sample_idx_q, 6'(c)};
  end

  assign cap_data_s = test_mode ? pattern_s : adc_data;

  // Pattern sample index: restarts with each acquisition run
  always_comb begin
    sample_idx_d = sample_idx_q;
    if (rise_s) begin
      sample_idx_d = '0;
    end else if (capture_s) begin
      sample_idx_d = sample_idx_q + 1'b1;
    end else begin
      sample_idx_d = sample_idx_q;
    end
  end

  // Pattern sample index register
  always_ff @(posedge data_clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      sample_idx_q <= '0;
    end else begin
      sample_idx_q <= sample_idx_d;
    end
  end
`else
  logic unused_test_mode_s;
  assign unused_test_mode_s = test_mode;
  assign cap_data_s         = adc_data;
`endif

  assign g_nxt_s = g_q + GW'(1);
  assign rise_s  = dma_ena && !dma_ena_q;
  assign hs_s    = tvalid_q && m_axis_tready;

  // FSM next state, stream register updates and overrun bookkeeping
  always_comb begin
    state_d       = state_q;
    g_d           = g_q;
    snap_d        = snap_q;
    tdata_d       = tdata_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    overrun_d     = overrun_q;
    overrun_cnt_d = overrun_cnt_q;
    dma_ena_d     = dma_ena;
    capture_s     = 1'b0;
    drop_s        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dma_ena) begin
          state_d = ST_WAIT_TICK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_TICK: begin
        if (!dma_ena) begin
          state_d = ST_IDLE;
        end else if (tick_s) begin
          capture_s = 1'b1;
        end else begin
          state_d = ST_WAIT_TICK;
        end
      end
      ST_SEND: begin
        if (hs_s && (g_q == G_LAST)) begin
          if (tick_s) begin
            capture_s = 1'b1;
          end else begin
            state_d  = dma_ena ? ST_WAIT_TICK : ST_IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end
        end else if (hs_s) begin
          g_d     = g_nxt_s;
          tdata_d = WORD_W'(snap_q[int'(g_nxt_s)*GRP_W +: GRP_W]);
          tlast_d = (g_nxt_s == G_LAST);
          drop_s  = tick_s;
        end else begin
          drop_s  = tick_s;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    endcase

    // A capture always restarts the word sequence from group 0
    if (capture_s) begin
      state_d  = ST_SEND;
      snap_d   = cap_data_s;
      g_d      = '0;
      tdata_d  = WORD_W'(cap_data_s[GRP_W-1:0]);
      tvalid_d = 1'b1;
      tlast_d  = (NUM_GROUPS == 1) ? 1'b1 : 1'b0;
    end else begin
      snap_d = snap_d;
    end

    if (rise_s) begin
      overrun_d     = 1'b0;
      overrun_cnt_d = 16'd0;
    end else if (drop_s) begin
      overrun_d     = 1'b1;
      overrun_cnt_d = sat_inc16(overrun_cnt_q);
    end else begin
      overrun_d     = overrun_q;
      overrun_cnt_d = overrun_cnt_q;
    end
  end

  // Datapath and control registers
  always_ff @(posedge data_clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q       <= ST_IDLE;
      g_q           <= '0;
      snap_q        <= '0;
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      overrun_q     <= 1'b0;
      overrun_cnt_q <= 16'd0;
      dma_ena_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      g_q           <= g_d;
      snap_q        <= snap_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      overrun_q     <= overrun_d;
      overrun_cnt_q <= overrun_cnt_d;
      dma_ena_q     <= dma_ena_d;
    end
  end

  assign new_sample    = capture_s;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign overrun       = overrun_q;
  assign overrun_cnt   = overrun_cnt_q;

endmodule

// File: doc/adc_sample_packer.md
ADC_SAMPLE_PACKER -- requirements
Module: adc_sample_packer

Interface
REQ-001 The block SHALL have parameter DECIM, default 40, meaning data_clk cycles per sample tick (1 MHz at 40 MHz); legal range 17..65535.
REQ-002 The block SHALL have parameter SAMPLE_W, default 16, meaning bits per ADC channel.
REQ-003 The block SHALL have parameter NUM_GROUPS, default 16, meaning 64-bit words per sample (4 channels per word, 64 channels).
REQ-004 The block SHALL have port data_clk, input, 1 bit: sole clock.
REQ-005 The block SHALL have port user_rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port dma_ena, input, 1 bit: acquisition enable.
REQ-007 The block SHALL have port adc_data, input, NUM_GROUPS*4*SAMPLE_W bits: channel c at bits [c*SAMPLE_W +: SAMPLE_W].
REQ-008 The block SHALL have port test_mode, input, 1 bit: selects test pattern (see REQ-030/031).
REQ-009 The block SHALL have port new_sample, output, 1 bit: one-cycle pulse on snapshot capture.
REQ-010 The block SHALL have ports m_axis_tdata (output, 64 bits), m_axis_tvalid (output, 1 bit), m_axis_tready (input, 1 bit) and m_axis_tlast (output, 1 bit): sample word stream.
REQ-011 The block SHALL have ports overrun (output, 1 bit, sticky flag) and overrun_cnt (output, 16 bits, dropped-tick count).

Function
REQ-012 The tick counter SHALL count 0..DECIM-1 while dma_ena=1, wrap to 0, and assert tick when value is DECIM-1; it SHALL be held at 0 while dma_ena=0.
REQ-013 The FSM SHALL have states IDLE, WAIT_TICK and SEND.
REQ-014 In IDLE with dma_ena=1, the FSM SHALL go to WAIT_TICK next cycle.
REQ-015 On tick in WAIT_TICK, the block SHALL latch adc_data into the snapshot register, pulse new_sample that same cycle, clear group index g, and enter SEND.
REQ-016 In SEND, m_axis_tvalid SHALL be 1 starting the cycle after capture, i.e. 1-cycle latency from new_sample.
REQ-017 In SEND, m_axis_tdata SHALL equal {ch[4g+3], ch[4g+2], ch[4g+1], ch[4g]} taken from the snapshot.
REQ-018 m_axis_tlast SHALL be 1 when g=NUM_GROUPS-1 and 0 otherwise.
REQ-019 tdata, tvalid and tlast SHALL hold stable while tvalid=1 and tready=0.
REQ-020 g SHALL advance only on tvalid&tready; after the handshake at g=NUM_GROUPS-1 the FSM SHALL go to WAIT_TICK, or to IDLE if dma_ena=0.
REQ-021 A tick in the same cycle as the final handshake SHALL capture a new snapshot and restart SEND at g=0, with no overrun.
REQ-022 A tick in SEND other than REQ-021 SHALL be dropped, set overrun, and increment overrun_cnt, saturating at 16'hFFFF.
REQ-023 A 0->1 edge of dma_ena SHALL clear overrun and overrun_cnt.
REQ-024 dma_ena=0 during SEND SHALL NOT truncate a group: the remaining words SHALL be sent, then the FSM SHALL go to IDLE.
REQ-025 dma_ena=0 in WAIT_TICK SHALL return the FSM to IDLE next cycle.
REQ-026 Outside SEND, m_axis_tvalid SHALL be 0; m_axis_tdata SHALL be 0 after reset.

Reset
REQ-027 Assertion of user_rstn=0 SHALL immediately force state IDLE and clear g, the tick counter, snapshot, new_sample, tvalid, tlast, overrun and overrun_cnt, including mid-SEND; a partial group is discarded.
REQ-028 Deassertion of reset SHALL be synchronised to data_clk; the first tick SHALL occur DECIM cycles after dma_ena=1 is seen.

Configuration
REQ-029 The block SHALL use macro ADC_PACKER_TEST_PATTERN_EN.
REQ-030 With ADC_PACKER_TEST_PATTERN_EN defined and test_mode=1, the snapshot SHALL capture pattern ch[c] = {sample_idx[SAMPLE_W-7:0], c[5:0]}, where sample_idx is a counter incremented per capture and cleared on the dma_ena rising edge.
REQ-031 Without ADC_PACKER_TEST_PATTERN_EN, test_mode SHALL be ignored and no pattern logic synthesised.

Structure
REQ-032 Shared include adc_packer_defs SHALL hold the FSM state encodings, the channels-per-word constant (4) and the word width (64).
REQ-033 The tick counter SHALL be sub-module adc_tick_gen (DECIM parameter; ena in; tick out).

Verification
REQ-034 A bench SHALL cover: DECIM=40, tready=1, ch[c]=16'h0100+c -> new_sample every 40 cycles; 16 words follow; word0=64'h0103_0102_0101_0100; tlast on word 15 only.
REQ-035 A bench SHALL cover: tready toggling 1010... -> data held stable during stalls; all 16 words delivered in order; no overrun.
REQ-036 A bench SHALL cover: tready=0 for 100 cycles after capture, DECIM=40 -> 2 ticks dropped, overrun=1, overrun_cnt=2; a later dma_ena re-enable clears both.
REQ-037 A bench SHALL cover: tready stalled so the final handshake coincides with a tick -> new_sample in that cycle, next word g=0, overrun_cnt=0.
REQ-038 A bench SHALL cover: dma_ena dropped at word 5 -> words 6..15 still sent, then IDLE; user_rstn pulsed at word 5 -> tvalid=0 immediately, no further words.
REQ-039 A bench SHALL cover: ADC_PACKER_TEST_PATTERN_EN defined, test_mode=1 -> sample 3 word0 = 64'h00C3_00C2_00C1_00C0.
